// File: rtl/dtc_feature_driver.sv
// dtc_feature_driver: serial feature collector and result returner for dtc_* classifiers; DTC_DRV_HIST_EN adds an 8-deep class history
module dtc_feature_driver #(
  parameter int N_FEAT = 13,
  parameter int LAT = 0,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic s_valid,
  output logic s_ready,
  input  logic s_bit,
  output logic [N_FEAT-1:0] dtc_inp,
  input  logic dtc_outp,
  output logic m_valid,
  input  logic m_ready,
  output logic m_class,
  input  logic cnt_clr,
  output logic [CNT_W-1:0] pos_count
`ifdef DTC_DRV_HIST_EN
  ,
  output logic [7:0] hist
`endif
);
  localparam logic [1:0] COLLECT = 2'd0, WAIT = 2'd1, HOLD = 2'd2;
  localparam int IW = N_FEAT > 1 ? $clog2(N_FEAT) : 1;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [N_FEAT-1:0] inp_q, inp_d;
  logic m_valid_q, m_valid_d, m_class_q, m_class_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic acc, hs, last;
  assign s_ready = !rst && state_q == COLLECT;
  assign acc = s_valid && s_ready;
  assign hs = m_valid_q && m_ready;
  assign last = idx_q == IW'(N_FEAT - 1);
  assign dtc_inp = inp_q;
  assign m_valid = m_valid_q;
  assign m_class = m_class_q;
  assign pos_count = cnt_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    wcnt_d = wcnt_q;
    inp_d = inp_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    if (acc) begin
      inp_d[idx_q] = s_bit;
      idx_d = last ? '0 : idx_q + 1'b1;
      state_d = last ? WAIT : COLLECT;
      wcnt_d = last ? 4'(LAT) : wcnt_q;
    end
    if (state_q == WAIT) begin
      state_d = wcnt_q == 4'd0 ? HOLD : WAIT;
      m_valid_d = wcnt_q == 4'd0;
      m_class_d = wcnt_q == 4'd0 ? dtc_outp : m_class_q;
      wcnt_d = wcnt_q == 4'd0 ? wcnt_q : wcnt_q - 1'b1;
    end
    if (hs) begin
      m_valid_d = 1'b0;
      state_d = COLLECT;
    end
    // clear has priority over a same-cycle positive handshake
    cnt_d = cnt_clr ? '0 : (hs && m_class_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q <= '0;
      wcnt_q <= '0;
      inp_q <= '0;
      m_valid_q <= 1'b0;
      m_class_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wcnt_q <= wcnt_d;
      inp_q <= inp_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef DTC_DRV_HIST_EN
  logic [7:0] hist_q, hist_d;
  assign hist = hist_q;
  always_comb hist_d = hs ? {hist_q[6:0], m_class_q} : hist_q;
  always_ff @(posedge clk) begin
    if (rst) hist_q <= '0;
    else hist_q <= hist_d;
  end
`endif
endmodule

// File: tb/tb_dtc_feature_driver.sv
// tb_dtc_feature_driver: randomized scoreboard bench for dtc_feature_driver with a stability-gated classifier stub
module tb_dtc_feature_driver;
  localparam int NF = 13, LT = 3, CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_bit = 1'b0, m_ready = 1'b0, cnt_clr = 1'b0;
  logic dtc_outp, s_ready, m_valid, m_class;
  logic [NF-1:0] dtc_inp;
  logic [CW-1:0] pos_count;
`ifdef DTC_DRV_HIST_EN
  logic [7:0] hist;
`endif
  typedef struct {logic [NF-1:0] vec; int acc;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, scnt = 0, policy = 1, stall_cnt = 0, prev_first = -1, exp_cnt = 0;
  bit stall_done = 0, mv_prev = 0;
  logic [7:0] exp_hist = '0;

  dtc_feature_driver #(.N_FEAT(NF), .LAT(LT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_bit(s_bit),
    .dtc_inp(dtc_inp), .dtc_outp(dtc_outp), .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .cnt_clr(cnt_clr), .pos_count(pos_count)
`ifdef DTC_DRV_HIST_EN
    , .hist(hist)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // stub answers dtc_inp[0] only once the vector has been stable for LT full cycles, else 0
  always @(posedge clk) scnt <= (rst || (s_valid && s_ready)) ? 0 : (scnt < 15 ? scnt + 1 : scnt);
  assign dtc_outp = scnt >= LT ? dtc_inp[0] : 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic tick(output bit acc, output int acc_cyc);
    m_ready = policy == 0 ? ($urandom_range(0, 2) != 0) : policy == 1 ? 1'b1 : (stall_cnt >= 20);
    cnt_clr = policy == 0 ? ($urandom_range(0, 19) == 0) : (policy == 2 && stall_cnt == 20 && !stall_done);
    @(negedge clk);
    acc = s_valid && s_ready;
    acc_cyc = cyc;
    if (policy == 2 && m_valid) begin
      if (m_ready) stall_done = 1;
      stall_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [NF-1:0] v, input int nb);
    bit acc;
    int ac, tries;
    for (int i = 0; i < nb; i++) begin
      acc = 0;
      tries = 0;
      while (!acc) begin
        s_valid = policy == 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_bit = s_valid ? v[i] : 1'($urandom);
        tick(acc, ac);
        if (++tries > 400) begin
          n_chk++;
          n_fail++;
          $display("FAIL accept_timeout: bit %0d not accepted at cycle %0d", i, cyc);
          finish_test();
        end
      end
      if (i == 0) begin
        if (policy == 1 && prev_first >= 0) chk("throughput", 32'(ac - prev_first), NF + LT + 2);
        prev_first = policy == 1 ? ac : -1;
      end
      if (i == NF - 1) exp_q.push_back('{vec: v, acc: ac});
    end
  endtask

  task automatic drain();
    bit acc;
    int ac;
    s_valid = 1'b0;
    for (int k = 0; k < 300 && (exp_q.size() != 0 || m_valid); k++) tick(acc, ac);
    chk("drain_pending", 32'(exp_q.size()), 0);
    prev_first = -1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    s_valid = 1'b1;
    s_bit = 1'b1;
    m_ready = 1'b1;
    cnt_clr = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("s_ready_in_rst", 32'(s_ready), 0);
      if (k > 0) begin
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_class", 32'(m_class), 0);
        chk("rst_dtc_inp", 32'(dtc_inp), 0);
        chk("rst_pos_count", 32'(pos_count), 0);
`ifdef DTC_DRV_HIST_EN
        chk("rst_hist", 32'(hist), 0);
`endif
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    s_valid = 1'b0;
    prev_first = -1;
  endtask

  // scoreboard monitor: observes each cycle's handshakes from settled signals
  always @(negedge clk) begin
    bit hs, cls;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
      exp_hist = '0;
      mv_prev = 0;
    end else begin
      chk("pos_count", 32'(pos_count), 32'(exp_cnt));
`ifdef DTC_DRV_HIST_EN
      chk("hist", 32'(hist), 32'(exp_hist));
`endif
      if (m_valid) begin
        chk("s_ready_busy", 32'(s_ready), 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_m_valid: got m_valid=1 expected 0 at cycle %0d", cyc);
        end else begin
          if (!mv_prev) chk("latency", 32'(cyc - exp_q[0].acc), LT + 2);
          chk("m_class", 32'(m_class), 32'(exp_q[0].vec[0]));
          chk("dtc_inp", 32'(dtc_inp), 32'(exp_q[0].vec));
        end
      end
      hs = m_valid && m_ready && exp_q.size() != 0;
      cls = hs ? exp_q[0].vec[0] : 1'b0;
      exp_cnt = cnt_clr ? 0 : (hs && cls && exp_cnt < CMAX) ? exp_cnt + 1 : exp_cnt;
      if (hs) begin
        exp_hist = {exp_hist[6:0], cls};
        void'(exp_q.pop_front());
      end
      mv_prev = m_valid;
    end
  end

  initial begin
    #500000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    finish_test();
  end

  initial begin
    logic [3:0] seq;
    seq = 4'b1011;
    do_reset(3);
    policy = 1;
    send_vec(NF'($urandom) | NF'(1), 7);
    do_reset(2);
    for (int k = 0; k < 4; k++) send_vec({12'($urandom), seq[k]}, NF);
    drain();
    chk("pos_after_1101", 32'(pos_count), 3);
`ifdef DTC_DRV_HIST_EN
    chk("hist_1101", 32'(hist), 32'h0D);
`endif
    for (int k = 0; k < 2; k++) send_vec({12'($urandom), 1'b1}, NF);
    drain();
    chk("pos_saturated", 32'(pos_count), CMAX);
    policy = 2;
    stall_cnt = 0;
    stall_done = 0;
    send_vec({12'($urandom), 1'b1}, NF);
    drain();
    chk("clear_wins", 32'(pos_count), 0);
    chk("stall_cycles", 32'(stall_cnt), 21);
    policy = 0;
    repeat (40) send_vec(NF'($urandom), NF);
    drain();
    finish_test();
  end
endmodule
